// File: rtl/cursor_pos_ctrl_pkg.sv
// Shared types and step arithmetic for the cursor position controller.
// Edge behaviour: CURSOR_WRAP_EN defined -> wrap at the edges, undefined -> saturate.
package cursor_pos_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_e;

    // Bit positions inside the direction vector {up, down, left, right}.
    localparam int DIR_UP = 3;
    localparam int DIR_DN = 2;
    localparam int DIR_LT = 1;
    localparam int DIR_RT = 0;

    // One step along one axis. Opposing inputs cancel. An 11-bit intermediate keeps
    // pos+step from overflowing before the edge comparison.
    function automatic logic [9:0] step_axis(input logic [9:0]  pos,
                                             input logic        inc,
                                             input logic        dec,
                                             input logic [10:0] step,
                                             input logic [10:0] max);
        logic [10:0] p;
        logic [10:0] r;
        p = {1'b0, pos};
        r = p;
        if (inc && !dec) begin
            r = p + step;
            if (r > max) begin
`ifdef CURSOR_WRAP_EN
                r = r - (max + 11'd1);
`else
                r = max;
`endif
            end
        end else if (dec && !inc) begin
            if (p < step) begin
`ifdef CURSOR_WRAP_EN
                r = p + (max + 11'd1) - step;
`else
                r = '0;
`endif
            end else begin
                r = p - step;
            end
        end
        return r[9:0];
    endfunction

endpackage

// File: rtl/cursor_pos_ctrl_btn_debounce.sv
// Two-flop synchroniser plus debounce counter for one raw pushbutton.
// The level output changes only after DEBOUNCE_CYC consecutive cycles of disagreement.
module cursor_pos_ctrl_btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;

    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                rise_d  = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/cursor_pos_ctrl.sv
// Pushbutton-driven cursor: debounced single step, hold-to-repeat, edge saturation
// (or wrap when CURSOR_WRAP_EN is defined), and a colour that advances per press.
module cursor_pos_ctrl
    import cursor_pos_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int HOLD_CYC     = 40_000_000,
    parameter int REPEAT_CYC   = 1_000_000,
    parameter int STEP         = 4,
    parameter int X_MAX        = 639,
    parameter int Y_MAX        = 479,
    parameter int X_INIT       = 320,
    parameter int Y_INIT       = 240
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_color,
    output logic [9:0] X_POS,
    output logic [9:0] Y_POS,
    output logic [2:0] color,
    output logic       moving
);

    localparam int TMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] REPEAT_LOAD = TW'(REPEAT_CYC - 1);

    logic [3:0] raw_dir;
    logic [3:0] dv;
    logic [3:0] dir_rise_unused;
    logic       color_lvl;
    logic       color_rise;

    assign raw_dir = {btn_up, btn_down, btn_left, btn_right};

    for (genvar i = 0; i < 4; i++) begin : g_dir_db
        cursor_pos_ctrl_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk     (clk),
            .clr     (clr),
            .btn_raw (raw_dir[i]),
            .level   (dv[i]),
            .rise    (dir_rise_unused[i])
        );
    end

    cursor_pos_ctrl_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_color_db (
        .clk     (clk),
        .clr     (clr),
        .btn_raw (btn_color),
        .level   (color_lvl),
        .rise    (color_rise)
    );

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [2:0]    color_q, color_d;
    logic          active;
    logic          do_step;

    assign active = |dv;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        do_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (active) begin
                    state_d = HOLD;
                    timer_d = HOLD_LOAD;
                    do_step = 1'b1;
                end
            end
            HOLD, REPEAT: begin
                if (!active) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    state_d = REPEAT;
                    timer_d = REPEAT_LOAD;
                    do_step = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // The step reads dv as it stands in the stepping cycle, not as it was at press time.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (do_step) begin
            x_d = step_axis(x_q, dv[DIR_RT], dv[DIR_LT], 11'(STEP), 11'(X_MAX));
            y_d = step_axis(y_q, dv[DIR_DN], dv[DIR_UP], 11'(STEP), 11'(Y_MAX));
        end
        color_d = color_rise ? color_q + 3'd1 : color_q;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            timer_q <= '0;
            x_q     <= 10'(X_INIT);
            y_q     <= 10'(Y_INIT);
            color_q <= 3'b111;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
        end
    end

    assign X_POS  = x_q;
    assign Y_POS  = y_q;
    assign color  = color_q;
    assign moving = (state_q != IDLE);

endmodule

// File: tb/tb_cursor_pos_ctrl.sv
// Directed bench for cursor_pos_ctrl with short timing parameters.
// Expected values in the edge-wrap scenario follow CURSOR_WRAP_EN when it is defined.
module tb_cursor_pos_ctrl;

    logic       clk;
    logic       clr;
    logic       btn_up, btn_down, btn_left, btn_right, btn_color;
    logic [9:0] X_POS, Y_POS;
    logic [2:0] color;
    logic       moving;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    cursor_pos_ctrl #(
        .DEBOUNCE_CYC (4),
        .HOLD_CYC     (20),
        .REPEAT_CYC   (5),
        .STEP         (4)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_color (btn_color),
        .X_POS     (X_POS),
        .Y_POS     (Y_POS),
        .color     (color),
        .moving    (moving)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        clr = 1'b0;
        tick(3);
        clr = 1'b1;
        tick(1);
    endtask

    initial begin
        int         guard;
        logic [2:0] exp_c;

        clr = 1'b1;
        {btn_up, btn_down, btn_left, btn_right, btn_color} = '0;
        #1 clr = 1'b0;
        #1;
        // 1. reset values, then held for 100 cycles
        check("rst_x", 16'(X_POS), 16'd320);
        check("rst_y", 16'(Y_POS), 16'd240);
        check("rst_color", 16'(color), 16'd7);
        check("rst_moving", 16'(moving), 16'd0);
        tick(2);
        clr = 1'b1;
        tick(100);
        check("idle_x", 16'(X_POS), 16'd320);
        check("idle_y", 16'(Y_POS), 16'd240);
        check("idle_color", 16'(color), 16'd7);
        check("idle_moving", 16'(moving), 16'd0);

        // 2. glitch is rejected; a hold gives step, hold delay, then repeat
        btn_right = 1'b1;
        tick(2);
        btn_right = 1'b0;
        tick(10);
        check("glitch_x", 16'(X_POS), 16'd320);
        check("glitch_moving", 16'(moving), 16'd0);
        btn_right = 1'b1;
        tick(6);
        check("deb_x_before", 16'(X_POS), 16'd320);
        tick(1);
        check("first_step_x", 16'(X_POS), 16'd324);
        check("first_step_moving", 16'(moving), 16'd1);
        tick(19);
        check("hold_x", 16'(X_POS), 16'd324);
        tick(1);
        check("hold_expire_x", 16'(X_POS), 16'd328);
        tick(4);
        check("repeat_wait_x", 16'(X_POS), 16'd328);
        tick(1);
        check("repeat_x", 16'(X_POS), 16'd332);
        btn_right = 1'b0;
        tick(20);
        check("release_x", 16'(X_POS), 16'd336);
        check("release_moving", 16'(moving), 16'd0);

        // 3. left edge: saturate (or wrap)
        btn_left = 1'b1;
        guard = 0;
        while (X_POS !== 10'd8 && guard < 2000) begin
            tick(1);
            guard++;
        end
        check("reach8_x", 16'(X_POS), 16'd8);
        tick(5);
        check("edge_x_4", 16'(X_POS), 16'd4);
        tick(5);
        check("edge_x_0", 16'(X_POS), 16'd0);
        tick(5);
`ifdef CURSOR_WRAP_EN
        check("edge_x_wrap", 16'(X_POS), 16'd636);
`else
        check("edge_x_sat", 16'(X_POS), 16'd0);
`endif
        btn_left = 1'b0;
        tick(20);
`ifdef CURSOR_WRAP_EN
        check("edge_release_x", 16'(X_POS), 16'd632);
`else
        check("edge_release_x", 16'(X_POS), 16'd0);
`endif
        check("edge_release_moving", 16'(moving), 16'd0);

        // 4. diagonal, then opposing buttons
        do_reset();
        btn_up   = 1'b1;
        btn_left = 1'b1;
        tick(7);
        check("diag_x", 16'(X_POS), 16'd316);
        check("diag_y", 16'(Y_POS), 16'd236);
        check("diag_moving", 16'(moving), 16'd1);
        btn_up   = 1'b0;
        btn_left = 1'b0;
        tick(20);
        check("diag_rel_x", 16'(X_POS), 16'd316);
        check("diag_rel_y", 16'(Y_POS), 16'd236);
        check("diag_rel_moving", 16'(moving), 16'd0);
        btn_up   = 1'b1;
        btn_down = 1'b1;
        tick(7);
        check("opp_y", 16'(Y_POS), 16'd236);
        check("opp_moving", 16'(moving), 16'd1);
        tick(30);
        check("opp_y_long", 16'(Y_POS), 16'd236);
        check("opp_x_long", 16'(X_POS), 16'd316);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(20);
        check("opp_rel_moving", 16'(moving), 16'd0);

        // 5. colour presses concurrent with a right move
        do_reset();
        btn_right = 1'b1;
        exp_c = 3'd0;
        for (int i = 0; i < 3; i++) begin
            btn_color = 1'b1;
            tick(10);
            btn_color = 1'b0;
            tick(10);
            check("color_press", 16'(color), 16'(exp_c));
            exp_c = exp_c + 3'd1;
        end
        check("color_move_x", 16'(X_POS), 16'd352);
        check("color_move_y", 16'(Y_POS), 16'd240);
        btn_right = 1'b0;
        tick(20);
        check("color_move_rel_x", 16'(X_POS), 16'd356);
        check("color_final", 16'(color), 16'd2);

        // 6. reset during REPEAT, button kept held through release
        do_reset();
        btn_right = 1'b1;
        tick(40);
        check("pre_clr_x", 16'(X_POS), 16'd336);
        check("pre_clr_moving", 16'(moving), 16'd1);
        clr = 1'b0;
        #1;
        check("clr_x", 16'(X_POS), 16'd320);
        check("clr_y", 16'(Y_POS), 16'd240);
        check("clr_color", 16'(color), 16'd7);
        check("clr_moving", 16'(moving), 16'd0);
        tick(3);
        clr = 1'b1;
        tick(6);
        check("post_clr_x_wait", 16'(X_POS), 16'd320);
        tick(1);
        check("post_clr_first_step", 16'(X_POS), 16'd324);
        btn_right = 1'b0;
        tick(20);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
